// File: rtl/armleocpu_tlb.sv
// Fully-associative translation cache between the page table walker and the fetch/LSU.
// One-cycle registered lookup; writes update in place, fill the lowest free slot, or evict round-robin.
module armleocpu_tlb #(
   parameter int ENTRIES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lookup_request,
   input  logic [19:0] lookup_virtual_address,
   output logic        lookup_done,
   output logic        lookup_hit,
   output logic [7:0]  lookup_access_bits,
   output logic [21:0] lookup_physical_address,
   input  logic        write_request,
   input  logic [19:0] write_virtual_address,
   input  logic [7:0]  write_access_bits,
   input  logic [21:0] write_physical_address,
   input  logic        invalidate_request
);

   localparam int ENTRIES_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [ENTRIES-1:0]   r_valid;
   logic [19:0]          r_vpn    [ENTRIES];
   logic [7:0]           r_access [ENTRIES];
   logic [21:0]          r_ppn    [ENTRIES];
   logic [ENTRIES_W-1:0] r_victim;

   logic        r_lookup_done;
   logic        r_lookup_hit;
   logic [7:0]  r_lookup_access;
   logic [21:0] r_lookup_ppn;

   logic                 w_lk_hit;
   logic [ENTRIES_W-1:0] w_lk_idx;
   logic                 w_wr_match;
   logic [ENTRIES_W-1:0] w_wr_match_idx;
   logic                 w_wr_free;
   logic [ENTRIES_W-1:0] w_wr_free_idx;
   logic [ENTRIES_W-1:0] w_wr_idx;
   logic                 w_wr_en;

   always_comb begin
      w_lk_hit = 1'b0;
      w_lk_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (r_valid[i] && (r_vpn[i] == lookup_virtual_address)) begin
            w_lk_hit = 1'b1;
            w_lk_idx = ENTRIES_W'(i);
         end
      end
   end

   // Scan downward so the lowest-index free entry is the one that sticks.
   always_comb begin
      w_wr_match     = 1'b0;
      w_wr_match_idx = '0;
      w_wr_free      = 1'b0;
      w_wr_free_idx  = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (r_valid[i] && (r_vpn[i] == write_virtual_address)) begin
            w_wr_match     = 1'b1;
            w_wr_match_idx = ENTRIES_W'(i);
         end
         if (!r_valid[i]) begin
            w_wr_free     = 1'b1;
            w_wr_free_idx = ENTRIES_W'(i);
         end
      end
   end

   assign w_wr_idx = w_wr_match ? w_wr_match_idx : (w_wr_free ? w_wr_free_idx : r_victim);
   assign w_wr_en  = write_request && !invalidate_request;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid         <= '0;
         r_victim        <= '0;
         r_lookup_done   <= 1'b0;
         r_lookup_hit    <= 1'b0;
         r_lookup_access <= '0;
         r_lookup_ppn    <= '0;
      end else begin
         r_lookup_done <= lookup_request;
         if (lookup_request) begin
            r_lookup_hit <= w_lk_hit;
            if (w_lk_hit) begin
               r_lookup_access <= r_access[w_lk_idx];
               r_lookup_ppn    <= r_ppn[w_lk_idx];
            end
         end
         if (invalidate_request) begin
            r_valid  <= '0;
            r_victim <= '0;
         end else if (write_request) begin
            r_valid[w_wr_idx] <= 1'b1;
            if (!w_wr_match && !w_wr_free)
               r_victim <= r_victim + ENTRIES_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_wr_en) begin
         r_vpn[w_wr_idx]    <= write_virtual_address;
         r_access[w_wr_idx] <= write_access_bits;
         r_ppn[w_wr_idx]    <= write_physical_address;
      end
   end

   assign lookup_done             = r_lookup_done;
   assign lookup_hit              = r_lookup_hit;
   assign lookup_access_bits      = r_lookup_access;
   assign lookup_physical_address = r_lookup_ppn;

endmodule

// File: tb/tb_armleocpu_tlb.sv
// Directed bench for armleocpu_tlb: lookup latency, in-place update, eviction order,
// invalidate interaction, same-cycle lookup/write and reset discarding a pending lookup.
module tb_armleocpu_tlb;

   logic        clk = 1'b0;
   logic        rst;
   logic        lookup_request;
   logic [19:0] lookup_virtual_address;
   logic        lookup_done;
   logic        lookup_hit;
   logic [7:0]  lookup_access_bits;
   logic [21:0] lookup_physical_address;
   logic        write_request;
   logic [19:0] write_virtual_address;
   logic [7:0]  write_access_bits;
   logic [21:0] write_physical_address;
   logic        invalidate_request;

   int total = 0;
   int bad   = 0;

   armleocpu_tlb #(.ENTRIES(8)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .lookup_request          (lookup_request),
      .lookup_virtual_address  (lookup_virtual_address),
      .lookup_done             (lookup_done),
      .lookup_hit              (lookup_hit),
      .lookup_access_bits      (lookup_access_bits),
      .lookup_physical_address (lookup_physical_address),
      .write_request           (write_request),
      .write_virtual_address   (write_virtual_address),
      .write_access_bits       (write_access_bits),
      .write_physical_address  (write_physical_address),
      .invalidate_request      (invalidate_request)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic do_write(input logic [19:0] v, input logic [21:0] p, input logic [7:0] a);
      write_request          = 1'b1;
      write_virtual_address  = v;
      write_physical_address = p;
      write_access_bits      = a;
      step();
      write_request = 1'b0;
   endtask

   task automatic do_lookup(input logic [19:0] v);
      lookup_request         = 1'b1;
      lookup_virtual_address = v;
      step();
      lookup_request = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({lookup_done, lookup_hit, lookup_access_bits, lookup_physical_address} !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs got done=%b hit=%b acc=%h ppn=%h exp all zero",
                  lookup_done, lookup_hit, lookup_access_bits, lookup_physical_address);
      end
      do_lookup(20'h12345);
      total++;
      if ({lookup_done, lookup_hit, lookup_access_bits, lookup_physical_address} !== 32'h8000_0000) begin
         bad++;
         $display("FAIL reset_lookup got done=%b hit=%b acc=%h ppn=%h exp done=1 hit=0 acc=00 ppn=000000",
                  lookup_done, lookup_hit, lookup_access_bits, lookup_physical_address);
      end
      step();
      total++;
      if (lookup_done !== 1'b0) begin
         bad++;
         $display("FAIL done_pulse got done=%b exp 0", lookup_done);
      end
   endtask

   task automatic test_hit_miss();
      do_reset();
      do_write(20'h12345, 22'h3ABCDE, 8'hCF);
      do_lookup(20'h12345);
      total++;
      if ({lookup_done, lookup_hit, lookup_access_bits, lookup_physical_address} !== {2'b11, 8'hCF, 22'h3ABCDE}) begin
         bad++;
         $display("FAIL basic_hit got done=%b hit=%b acc=%h ppn=%h exp done=1 hit=1 acc=cf ppn=3abcde",
                  lookup_done, lookup_hit, lookup_access_bits, lookup_physical_address);
      end
      do_lookup(20'h12346);
      total++;
      if ({lookup_done, lookup_hit, lookup_access_bits, lookup_physical_address} !== {2'b10, 8'hCF, 22'h3ABCDE}) begin
         bad++;
         $display("FAIL miss_holds got done=%b hit=%b acc=%h ppn=%h exp done=1 hit=0 acc=cf ppn=3abcde",
                  lookup_done, lookup_hit, lookup_access_bits, lookup_physical_address);
      end
      step();
      total++;
      if (lookup_hit !== 1'b0) begin
         bad++;
         $display("FAIL hit_stable got hit=%b exp 0", lookup_hit);
      end
   endtask

   task automatic test_update_in_place();
      do_reset();
      do_write(20'h00010, 22'h000001, 8'h11);
      do_write(20'h00010, 22'h000002, 8'h22);
      do_lookup(20'h00010);
      total++;
      if ({lookup_hit, lookup_access_bits, lookup_physical_address} !== {1'b1, 8'h22, 22'h000002}) begin
         bad++;
         $display("FAIL update_value got hit=%b acc=%h ppn=%h exp hit=1 acc=22 ppn=000002",
                  lookup_hit, lookup_access_bits, lookup_physical_address);
      end
      // Seven more writes fill entries 1..7; the ninth distinct VPN must evict entry 0 (VPN 0x10).
      for (int i = 0; i < 7; i++) do_write(20'h00020 + 20'(i), 22'h000100 + 22'(i), 8'h01);
      do_lookup(20'h00010);
      total++;
      if (lookup_hit !== 1'b1) begin
         bad++;
         $display("FAIL update_full got hit=%b exp 1", lookup_hit);
      end
      do_write(20'h00027, 22'h000107, 8'h01);
      do_lookup(20'h00010);
      total++;
      if (lookup_hit !== 1'b0) begin
         bad++;
         $display("FAIL update_evict0 got hit=%b exp 0", lookup_hit);
      end
      do_lookup(20'h00020);
      total++;
      if ({lookup_hit, lookup_physical_address} !== {1'b1, 22'h000100}) begin
         bad++;
         $display("FAIL update_keep1 got hit=%b ppn=%h exp hit=1 ppn=000100", lookup_hit, lookup_physical_address);
      end
   endtask

   task automatic test_eviction();
      do_reset();
      for (int i = 0; i < 11; i++) do_write(20'(i), 22'h10 + 22'(i), 8'(i));
      // Back-to-back lookups: one result per cycle.
      for (int i = 0; i < 11; i++) begin
         do_lookup(20'(i));
         total++;
         if (lookup_done !== 1'b1 || lookup_hit !== (i >= 3)) begin
            bad++;
            $display("FAIL evict_order vpn=%0d got done=%b hit=%b exp done=1 hit=%b",
                     i, lookup_done, lookup_hit, (i >= 3));
         end else if (i >= 3 && lookup_physical_address !== 22'h10 + 22'(i)) begin
            bad++;
            $display("FAIL evict_ppn vpn=%0d got ppn=%h exp %h", i, lookup_physical_address, 22'h10 + 22'(i));
         end
      end
      // Victim is 3: five writes hit entries 3..7, then the pointer wraps and entry 0 (VPN 8) goes.
      for (int i = 11; i < 17; i++) do_write(20'(i), 22'h10 + 22'(i), 8'(i));
      do_lookup(20'd8);
      total++;
      if (lookup_hit !== 1'b0) begin
         bad++;
         $display("FAIL wrap_evict8 got hit=%b exp 0", lookup_hit);
      end
      do_lookup(20'd9);
      total++;
      if (lookup_hit !== 1'b1) begin
         bad++;
         $display("FAIL wrap_keep9 got hit=%b exp 1", lookup_hit);
      end
      do_lookup(20'd16);
      total++;
      if ({lookup_hit, lookup_access_bits} !== {1'b1, 8'd16}) begin
         bad++;
         $display("FAIL wrap_new16 got hit=%b acc=%h exp hit=1 acc=10", lookup_hit, lookup_access_bits);
      end
   endtask

   task automatic test_invalidate();
      do_reset();
      for (int i = 0; i < 11; i++) do_write(20'(i), 22'h20 + 22'(i), 8'h5A);
      invalidate_request = 1'b1;
      do_write(20'h00055, 22'h000055, 8'h55);
      invalidate_request = 1'b0;
      total++;
      if ({lookup_done, lookup_hit} !== 2'b00) begin
         bad++;
         $display("FAIL inv_quiet got done=%b hit=%b exp 0 0", lookup_done, lookup_hit);
      end
      // Redo with a lookup in the invalidate cycle.
      for (int i = 0; i < 11; i++) do_write(20'(i), 22'h20 + 22'(i), 8'h5A);
      invalidate_request = 1'b1;
      write_request = 1'b1;
      write_virtual_address = 20'h00055;
      write_physical_address = 22'h000055;
      write_access_bits = 8'h55;
      do_lookup(20'd3);
      invalidate_request = 1'b0;
      write_request = 1'b0;
      total++;
      if ({lookup_done, lookup_hit, lookup_physical_address} !== {2'b11, 22'h23}) begin
         bad++;
         $display("FAIL inv_same_cycle got done=%b hit=%b ppn=%h exp done=1 hit=1 ppn=000023",
                  lookup_done, lookup_hit, lookup_physical_address);
      end
      do_lookup(20'd3);
      total++;
      if (lookup_hit !== 1'b0) begin
         bad++;
         $display("FAIL inv_cleared got hit=%b exp 0", lookup_hit);
      end
      do_lookup(20'h00055);
      total++;
      if (lookup_hit !== 1'b0) begin
         bad++;
         $display("FAIL inv_write_dropped got hit=%b exp 0", lookup_hit);
      end
      // Victim was 3 before invalidate; after reset to 0 the first overflow evicts entry 0.
      for (int i = 0; i < 9; i++) do_write(20'h200 + 20'(i), 22'h200 + 22'(i), 8'h01);
      do_lookup(20'h200);
      total++;
      if (lookup_hit !== 1'b0) begin
         bad++;
         $display("FAIL inv_victim0 got hit=%b exp 0", lookup_hit);
      end
      do_lookup(20'h203);
      total++;
      if (lookup_hit !== 1'b1) begin
         bad++;
         $display("FAIL inv_keep3 got hit=%b exp 1", lookup_hit);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      write_request = 1'b1;
      write_virtual_address = 20'h00777;
      write_physical_address = 22'h00ABCD;
      write_access_bits = 8'h3C;
      do_lookup(20'h00777);
      write_request = 1'b0;
      total++;
      if ({lookup_done, lookup_hit} !== 2'b10) begin
         bad++;
         $display("FAIL same_cycle_miss got done=%b hit=%b exp done=1 hit=0", lookup_done, lookup_hit);
      end
      do_lookup(20'h00777);
      total++;
      if ({lookup_hit, lookup_access_bits, lookup_physical_address} !== {1'b1, 8'h3C, 22'h00ABCD}) begin
         bad++;
         $display("FAIL next_cycle_hit got hit=%b acc=%h ppn=%h exp hit=1 acc=3c ppn=00abcd",
                  lookup_hit, lookup_access_bits, lookup_physical_address);
      end
      rst = 1'b1;
      do_lookup(20'h00777);
      rst = 1'b0;
      total++;
      if ({lookup_done, lookup_hit, lookup_physical_address} !== 24'h0) begin
         bad++;
         $display("FAIL rst_discard got done=%b hit=%b ppn=%h exp all zero",
                  lookup_done, lookup_hit, lookup_physical_address);
      end
      do_lookup(20'h00777);
      total++;
      if ({lookup_done, lookup_hit} !== 2'b10) begin
         bad++;
         $display("FAIL rst_cleared got done=%b hit=%b exp done=1 hit=0", lookup_done, lookup_hit);
      end
   endtask

   initial begin
      rst                    = 1'b1;
      lookup_request         = 1'b0;
      lookup_virtual_address = '0;
      write_request          = 1'b0;
      write_virtual_address  = '0;
      write_access_bits      = '0;
      write_physical_address = '0;
      invalidate_request     = 1'b0;
      test_reset();
      test_hit_miss();
      test_update_in_place();
      test_eviction();
      test_invalidate();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
